// File: rtl/ram_pkg.sv
// Shared defaults and types for the 256x4 data memory.
// Also holds the clear-sweep controller state encoding.
package ram_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 4;

  // ST_SWEEP: zero-fill in progress (or first edge after reset); ST_READY: external access open.
  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_READY = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset zero-fill sequencer; owns the ready flag and arbitrates the single
// write port between the sweep and the external bus.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W         = RAM_ADDR_W,
  parameter int DATA_W         = RAM_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  sweep_state_e      state_reg, state_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic              sweep_wr;

  // Falling-edge sequencing keeps the sweep aligned with the memory write edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_SWEEP;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sweep_wr   = 1'b0;
    case (state_reg)
      ST_SWEEP: begin
        if (CLEAR_ON_RESET) begin
          sweep_wr = 1'b1;
          // Counter parks on the last address so it never wraps into a second pass.
          if (count_reg == LAST_ADDR) begin
            state_next = ST_READY;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end else begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
    endcase
  end

  assign ready = (state_reg == ST_READY);

  // An unknown we_n leaves wr_en unknown, which the memory treats as no write.
  assign wr_en   = ready ? (we_n == 1'b0) : sweep_wr;
  assign wr_addr = ready ? address : count_reg;
  assign wr_data = ready ? data_in : '0;

endmodule

// File: rtl/ram_256x4.sv
// General-purpose CPU data memory: falling-edge write, combinational read,
// shared tri-state data bus, zero-filled after every reset.
module ram_256x4
  import ram_pkg::*;
#(
  parameter int ADDR_W         = RAM_ADDR_W,
  parameter int DATA_W         = RAM_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  input  logic              we_n,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] read_data;

  ram_clear_ctrl #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_n    (we_n),
    .address (address),
    .data_in (data),
    .ready   (ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Storage is deliberately unreset; the sweep provides the defined contents.
  always_ff @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign read_data = ready ? mem[address] : '0;
  assign data      = (we_n == 1'b1) ? read_data : 'z;

  we_n_known_a : assert property (@(negedge clk) disable iff (!rst_n) !$isunknown(we_n));

endmodule

// File: tb/tb_ram_256x4.sv
// Directed plus randomized checks of ram_256x4 against an array model.
module tb_ram_256x4;

  logic       clk;
  logic       rst_n;
  logic [7:0] address;
  logic       we_n;
  logic       ready;
  logic [3:0] drv_val;
  logic       drv_en;
  wire  [3:0] data;

  int checks = 0;
  int errors = 0;

  logic [3:0] model [256];
  logic       model_ready;

  assign data = drv_en ? drv_val : 4'bz;

  ram_256x4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .data    (data),
    .we_n    (we_n),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] expect_rd(input logic [7:0] a);
    return model_ready ? model[a] : 4'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 4'h0;
    model_ready = 1'b1;
  endtask

  // Counts falling edges after release: ready must appear exactly on the 256th.
  task automatic wait_sweep();
    for (int e = 1; e <= 256; e++) begin
      @(negedge clk); #1;
      if (e == 1 || e == 128 || e == 255 || e == 256)
        chk($sformatf("sweep_ready_e%0d", e), {7'd0, ready}, {7'd0, (e == 256)});
    end
    model_clear();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] v);
    @(posedge clk); #1;
    address = a; drv_val = v; drv_en = 1'b1; we_n = 1'b0;
    #1 chk("bus_master_drive", {4'd0, data}, {4'd0, v});
    @(negedge clk); #1;
    if (model_ready) model[a] = v;
    we_n = 1'b1; drv_en = 1'b0;
    #1 chk("read_after_write", {4'd0, data}, {4'd0, expect_rd(a)});
    $display("WR addr=%02h data=%h ready=%0d", a, v, ready);
  endtask

  task automatic do_read(input logic [7:0] a, input string tag);
    @(posedge clk); #1;
    address = a; we_n = 1'b1; drv_en = 1'b0;
    #1 chk(tag, {4'd0, data}, {4'd0, expect_rd(a)});
    $display("RD addr=%02h data=%h exp=%h", a, data, expect_rd(a));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; model_ready = 1'b0;
    #1 chk("reset_ready_low", {7'd0, ready}, 8'd0);
    @(posedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] a;
    logic [3:0] v;
    int         waited;
    rst_n = 1'b0; we_n = 1'b1; address = 8'h00; drv_val = 4'h0; drv_en = 1'b0;
    model_ready = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 4'h0;

    #2;
    chk("reset_ready", {7'd0, ready}, 8'd0);
    chk("reset_read_zero", {4'd0, data}, 8'd0);
    @(posedge clk);
    rst_n = 1'b1;
    wait_sweep();

    do_read(8'h00, "clear_00");
    do_read(8'h7F, "clear_7f");
    do_read(8'hFF, "clear_ff");

    do_write(8'h01, 4'h3);
    do_read(8'h04, "rd_04");
    do_read(8'h01, "rd_01");
    do_write(8'h05, 4'h6);
    do_read(8'h01, "rd_01_again");
    do_read(8'h05, "rd_05");

    // Bus turnaround: master drives 0xA, then releases and the RAM takes over.
    @(posedge clk); #1;
    address = 8'h05; drv_val = 4'hA; drv_en = 1'b1; we_n = 1'b0;
    #1 chk("bus_no_contention", {4'd0, data}, 8'h0A);
    drv_en = 1'b0; we_n = 1'b1;
    #1 chk("bus_ram_drives", {4'd0, data}, {4'd0, expect_rd(8'h05)});
    @(negedge clk); #1;

    do_write(8'h00, 4'hC);
    do_write(8'hFF, 4'h9);
    do_read(8'h00, "boundary_lo");
    do_read(8'hFF, "boundary_hi");

    // Accesses while the sweep is running are ignored and read as zero.
    pulse_reset();
    do_write(8'h10, 4'hF);
    do_read(8'h10, "sweep_read_zero");
    waited = 0;
    while (ready !== 1'b1 && waited < 400) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("sweep_done_in_bound", {7'd0, ready}, 8'd1);
    model_clear();
    do_read(8'h10, "sweep_write_ignored");
    do_read(8'hFF, "sweep_cleared_ff");

    // Reset mid-sweep restarts the count from zero.
    do_write(8'h20, 4'h9);
    do_read(8'h20, "pre_reset_value");
    pulse_reset();
    repeat (100) @(negedge clk);
    #1 chk("mid_sweep_not_ready", {7'd0, ready}, 8'd0);
    pulse_reset();
    wait_sweep();
    do_read(8'h20, "post_reset_cleared");

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: a = 8'h00;
        1: a = 8'hFF;
        default: a = 8'($urandom_range(0, 255));
      endcase
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) do_write(a, v);
      else do_read(a, "rand_read");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_256x4.md
Name: ram_256x4

Overview:
- Single-port synchronous-write, asynchronous-read RAM; 256 words x 4 bits by default.
- Uses one shared bidirectional data bus and an active-low write enable.
- Serves as the CPU's general-purpose data memory.
- After reset, a built-in sweep clears every location to zero before normal access is allowed.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W words.
- DATA_W, 4, word width in bits.
- CLEAR_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = no sweep, contents undefined after reset.

Ports:
- clk  input  1  system clock; writes commit on the falling edge.
- rst_n  input  1  asynchronous, active-low reset.
- address  input  ADDR_W  word address.
- data  inout  DATA_W  bidirectional data bus; driven by the RAM only during reads.
- we_n  input  1  write enable, active low; 1 = read, 0 = write.
- ready  output  1  high when the RAM accepts accesses (clear sweep finished).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Bus drive:
  - data is driven by the RAM iff we_n=1. This is purely combinational from we_n, with no clock dependency.
  - When we_n=0, data is high-Z and the external master drives it.
- Read:
  - Asynchronous, zero-cycle latency: data = mem[address] while we_n=1 and ready=1.
  - A change of address is reflected combinationally.
  - While ready=0 and we_n=1, the RAM drives all zeros.
- Write:
  - On each falling edge of clk with we_n=0 and ready=1: mem[address] <= data.
  - The half-cycle offset gives address/data set-up margin from rising-edge launch.
  - Writes with ready=0 are ignored; memory is unchanged.
- Read-after-write: the same address read after the write edge returns the new value immediately.
- Reset (rst_n=0):
  - Asynchronously forces ready=0 and clears the sweep counter to 0.
  - Memory contents are not touched asynchronously.
- Clear sweep (CLEAR_ON_RESET=1):
  - After rst_n deasserts, each falling edge writes 0 to mem[counter] and increments counter.
  - After location 2**ADDR_W-1 is written, ready goes 1 on that same edge.
  - The sweep takes exactly 2**ADDR_W falling edges (256 by default).
  - The sweep counter does not wrap or restart by itself.
- Reset mid-sweep: the sweep restarts from address 0 after rst_n deasserts again.
- CLEAR_ON_RESET=0: ready=1 at the first falling edge after rst_n deasserts.
- Reset values: ready=0, counter=0, data bus released whenever we_n=0.
- Boundaries:
  - address 0 and 2**ADDR_W-1 are fully usable.
  - There is no address wrap; address is always in range by width.
- Simultaneous events:
  - A we_n change coincident with the falling edge uses the value settled before the edge (normal flop sampling).
  - Reset asserted on a write edge: reset wins and the write is not guaranteed.
- X on we_n while ready=1 must not corrupt memory in simulation. An assertion flags X on we_n at a falling edge.

Decomposition:
- Package ram_pkg: default ADDR_W and DATA_W constants.
- Sub-module ram_clear_ctrl: holds the sweep counter and ready flag, and muxes the write port between the sweep and the external port.
- Top level contains the memory array, the write logic and the tri-state driver.

Test Plan:
- Reset then clear: pulse rst_n low, wait 256 falling edges -> ready rises on the 256th edge; read addresses 0x00, 0x7F and 0xFF with we_n=1 -> data=0.
- Write then read: address=0x01, data=3, we_n=0 across a falling edge; then we_n=1 -> data=3 with no clock edge needed. Address 0x04 -> 0; back to 0x01 -> 3.
- Second write: address=0x05, data=6, we_n=0 for one edge; then we_n=1 -> address 0x01 reads 3 and 0x05 reads 6.
- Bus direction: we_n=0 with the master driving 0xA -> the bus resolves to 0xA with no contention (no X). Master releases and we_n=1 -> the RAM drives the value immediately.
- Access during sweep: write 0xF to 0x10 while ready=0 -> ignored; after ready, 0x10 reads 0. Reads while ready=0 return 0.
- Reset mid-sweep: assert rst_n after 100 edges -> ready stays 0, the sweep restarts and ready rises 256 edges after release. A value written before reset reads 0 afterwards.
